fb_tap_line: RTL

- Parametrised shared input delay line for the nonuniform filterbank. It replaces the fixed shift-register controller and the externally supplied decimation phase.
- Stores the last DEPTH input samples in a circular buffer.
- Generates the decimation frame strobe internally and holds the input with a frame handshake while channel filters run.
- Serves taps to time-multiplexed channel MACs through a registered random-access read port.

---
 rtl/fb_tap_line.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/fb_tap_line.sv
// fb_tap_line: shared input delay line for the nonuniform filterbank.
// The last DEPTH accepted samples sit in a circular buffer. Every DECIM
// accepted samples, once the line is primed, the block raises frame_strobe
// and then holds its input until the channel filters send frame_ack.
// Taps are read through a registered random-access port with 1-cycle latency.
// Optional build macro SYMM_PAIR_EN: the read port returns the symmetric pair
// sum x[k] + x[DEPTH-1-k] (DATA_W+1 bits) for linear-phase channels.
module fb_tap_line #(
   parameter int DATA_W = 14,
   parameter int DEPTH  = 119,
   parameter int DECIM  = 60,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk_en,
   input  logic              reset,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              frame_strobe,
   input  logic              frame_ack,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_tap,
   output logic              rd_valid,
`ifdef SYMM_PAIR_EN
   output logic [DATA_W:0]   rd_data,
`else
   output logic [DATA_W-1:0] rd_data,
`endif
   output logic              primed
);

`ifdef SYMM_PAIR_EN
   localparam int OUT_W = DATA_W + 1;
`else
   localparam int OUT_W = DATA_W;
`endif

   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int PH_W  = (DECIM > 1) ? $clog2(DECIM) : 1;

   localparam logic [CNT_W-1:0]  FILL_FULL = CNT_W'(DEPTH);
   localparam logic [ADDR_W-1:0] PTR_LAST  = ADDR_W'(DEPTH - 1);
   localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(DECIM - 1);
   localparam logic [ADDR_W:0]   IDX_OFS   = (ADDR_W + 1)'(DEPTH - 1);
   localparam logic [ADDR_W:0]   IDX_DEPTH = (ADDR_W + 1)'(DEPTH);

   typedef enum logic [1:0] {
      FILL = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0]    fill_cnt_q, fill_cnt_d;
   logic [PH_W-1:0]     phase_cnt_q, phase_cnt_d;
   logic                in_ready_q, in_ready_d;
   logic                frame_strobe_q, frame_strobe_d;
   logic                primed_q, primed_d;
   logic                rd_valid_q, rd_valid_d;
   logic [OUT_W-1:0]    rd_data_q, rd_data_d;
   logic                accept;
   logic [DATA_W-1:0]   mem_q [DEPTH];

   // Physical buffer slot of a logical tap (0 = newest), given the write pointer.
   function automatic logic [ADDR_W-1:0] tap_addr(input logic [ADDR_W-1:0] ptr,
                                                  input logic [ADDR_W-1:0] tap);
      logic [ADDR_W:0] idx;
      idx = {1'b0, ptr} + IDX_OFS - {1'b0, tap};
      if (idx >= IDX_DEPTH) idx = idx - IDX_DEPTH;
      return idx[ADDR_W-1:0];
   endfunction

   // Next-state logic: write pointer, fill/phase counters and frame control.
   always_comb begin
      // NOTE: every variable gets a default first so no path infers a latch.
      state_d        = state_q;
      wr_ptr_d       = wr_ptr_q;
      fill_cnt_d     = fill_cnt_q;
      phase_cnt_d    = phase_cnt_q;
      frame_strobe_d = 1'b0;
      accept         = in_valid && in_ready_q;

      if (accept) begin
         wr_ptr_d    = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
         phase_cnt_d = (phase_cnt_q == PH_LAST) ? '0 : phase_cnt_q + 1'b1;
         if (fill_cnt_q != FILL_FULL) fill_cnt_d = fill_cnt_q + 1'b1;
      end

      case (state_q)
         FILL, RUN: begin
            if (accept && (phase_cnt_q == PH_LAST) && (fill_cnt_d == FILL_FULL)) begin
               state_d        = HOLD;
               frame_strobe_d = 1'b1;
            end else if (fill_cnt_d == FILL_FULL) begin
               state_d = RUN;
            end
         end
         HOLD: begin
            if (frame_ack) state_d = RUN;
         end
         default: state_d = FILL;
      endcase

      in_ready_d = (state_d != HOLD);
      primed_d   = (fill_cnt_d == FILL_FULL);
   end

`ifdef SYMM_PAIR_EN
   localparam logic [ADDR_W-1:0] HALF_TAP = ADDR_W'(DEPTH / 2);
   localparam logic [ADDR_W-1:0] MID_TAP  = ADDR_W'((DEPTH - 1) / 2);
   localparam logic              ODD_LEN  = (DEPTH % 2) == 1;

   logic [ADDR_W-1:0] pair_tap;
   logic [DATA_W-1:0] near_val, far_val;

   // Read port: symmetric pair sum, each operand masked by the fill level.
   always_comb begin
      pair_tap   = PTR_LAST - rd_tap;
      near_val   = '0;
      far_val    = '0;
      rd_data_d  = '0;
      rd_valid_d = rd_req;
      if (CNT_W'(rd_tap) < fill_cnt_q) near_val = mem_q[tap_addr(wr_ptr_q, rd_tap)];
      if (CNT_W'(pair_tap) < fill_cnt_q) far_val = mem_q[tap_addr(wr_ptr_q, pair_tap)];
      if (rd_req) begin
         if (rd_tap < HALF_TAP)
            rd_data_d = {near_val[DATA_W-1], near_val} + {far_val[DATA_W-1], far_val};
         else if (ODD_LEN && (rd_tap == MID_TAP))
            rd_data_d = {near_val[DATA_W-1], near_val};
      end
   end
`else
   // Read port: single tap, zero for taps beyond the fill level.
   always_comb begin
      rd_data_d  = '0;
      rd_valid_d = rd_req;
      if (rd_req && (CNT_W'(rd_tap) < fill_cnt_q))
         rd_data_d = mem_q[tap_addr(wr_ptr_q, rd_tap)];
   end
`endif

   // Control and read-port registers with synchronous reset.
   always_ff @(posedge clk_en) begin
      // NOTE: sequential state uses non-blocking assignment so all flops update together.
      if (reset) begin
         state_q        <= FILL;
         wr_ptr_q       <= '0;
         fill_cnt_q     <= '0;
         phase_cnt_q    <= '0;
         in_ready_q     <= 1'b0;
         frame_strobe_q <= 1'b0;
         primed_q       <= 1'b0;
         rd_valid_q     <= 1'b0;
         rd_data_q      <= '0;
      end else begin
         state_q        <= state_d;
         wr_ptr_q       <= wr_ptr_d;
         fill_cnt_q     <= fill_cnt_d;
         phase_cnt_q    <= phase_cnt_d;
         in_ready_q     <= in_ready_d;
         frame_strobe_q <= frame_strobe_d;
         primed_q       <= primed_d;
         rd_valid_q     <= rd_valid_d;
         rd_data_q      <= rd_data_d;
      end
   end

   // Sample storage written on accept.
   always_ff @(posedge clk_en) begin
      // NOTE: the buffer is not reset; fill_cnt masks slots never written.
      if (accept && !reset) mem_q[wr_ptr_q] <= in_data;
   end

   assign in_ready     = in_ready_q;
   assign frame_strobe = frame_strobe_q;
   assign primed       = primed_q;
   assign rd_valid     = rd_valid_q;
   assign rd_data      = rd_data_q;

endmodule
